// File: rtl/serial_adder_if.sv
// ============================================================================
// Module  : serial_adder_if
// Brief   : Start/busy/done request bus for serial_adder. The sub line exists
//           only when SERIAL_ADDER_SUB_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif
endinterface

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module  : serial_adder
// Brief   : Multi-cycle WIDTH-bit adder reusing one DIGIT-bit ripple slice per
//           clock. Optional subtract mode enabled by SERIAL_ADDER_SUB_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    serial_adder_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] w_beff;
    logic             w_ceff;
    logic [DIGIT-1:0] w_dsum;
    logic             w_dcarry;
    logic [WIDTH-1:0] w_part_next;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1; the caller's carry-in is overridden.
    assign w_beff = bus.sub ? ~bus.b : bus.b;
    assign w_ceff = bus.sub ? 1'b1   : bus.cin;
`else
    assign w_beff = bus.b;
    assign w_ceff = bus.cin;
`endif

    always_comb begin
        logic c;
        c      = carry_q;
        w_dsum = '0;
        for (int i = 0; i < DIGIT; i++) begin
            w_dsum[i] = a_q[i] ^ b_q[i] ^ c;
            c         = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        w_dcarry = c;
    end

    // New digit enters at the MSB end; after STEPS shifts the result is aligned.
    assign w_part_next = WIDTH'({w_dsum, part_q} >> DIGIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        part_d  = part_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    state_d = S_ADD;
                    cnt_d   = '0;
                    a_d     = bus.a;
                    b_d     = w_beff;
                    carry_d = w_ceff;
                    part_d  = '0;
                    amsb_d  = bus.a[WIDTH-1];
                    bmsb_d  = w_beff[WIDTH-1];
                end
            end
            S_ADD: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = w_dcarry;
                part_d  = w_part_next;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = S_DONE;
                    sum_d   = w_part_next;
                    cout_d  = w_dcarry;
                    ovf_d   = (amsb_q == bmsb_q) && (w_part_next[WIDTH-1] != amsb_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            part_q  <= '0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            part_q  <= part_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == S_ADD);
    assign bus.done = (state_q == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module  : tb_serial_adder
// Brief   : Bench driving a DIGIT=1 and a DIGIT=4 serial_adder with shared
//           stimulus, checked against an arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_start, s_cin, s_sub, sub_eff;
    logic [W-1:0] s_a, s_b;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           d1_dones = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) if1 ();
    serial_adder_if #(.WIDTH(W)) if4 ();

    assign if1.start = s_start;
    assign if1.a     = s_a;
    assign if1.b     = s_b;
    assign if1.cin   = s_cin;
    assign if4.start = s_start;
    assign if4.a     = s_a;
    assign if4.b     = s_b;
    assign if4.cin   = s_cin;
`ifdef SERIAL_ADDER_SUB_EN
    assign if1.sub = s_sub;
    assign if4.sub = s_sub;
    assign sub_eff = s_sub;
`else
    assign sub_eff = 1'b0;
`endif

    serial_adder #(.WIDTH(W), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    serial_adder #(.WIDTH(W), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    // Result packed as {ovf, cout, sum}
    function automatic logic [W+1:0] ref_add(logic [W-1:0] a, logic [W-1:0] b, logic c, logic s);
        logic [W-1:0] be;
        logic [W:0]   t;
        logic         ov;
        be = s ? ~b : b;
        t  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (s ? 1'b1 : c)};
        ov = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
        return {ov, t[W], t[W-1:0]};
    endfunction

    function automatic int steps_of(int k);
        return (k == 0) ? 8 : 2;
    endfunction

    int             m_left [2];
    logic           m_done [2];
    logic [W+1:0]   m_res  [2];
    logic [W+1:0]   m_pend [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_left[k] <= 0;
                m_done[k] <= 1'b0;
                m_res[k]  <= '0;
                m_pend[k] <= '0;
            end else if (m_left[k] > 0) begin
                m_left[k] <= m_left[k] - 1;
                m_done[k] <= (m_left[k] == 1);
                if (m_left[k] == 1) m_res[k] <= m_pend[k];
            end else begin
                m_done[k] <= 1'b0;
                if (s_start) begin
                    m_left[k] <= steps_of(k);
                    m_pend[k] <= ref_add(s_a, s_b, s_cin, sub_eff);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (if1.done) d1_dones <= d1_dones + 1;
        chk("m1_busy", 32'(if1.busy), 32'(m_left[0] > 0));
        chk("m1_done", 32'(if1.done), 32'(m_done[0]));
        chk("m1_res",  32'({if1.ovf, if1.cout, if1.sum}), 32'(m_res[0]));
        chk("m4_busy", 32'(if4.busy), 32'(m_left[1] > 0));
        chk("m4_done", 32'(if4.done), 32'(m_done[1]));
        chk("m4_res",  32'({if4.ovf, if4.cout, if4.sum}), 32'(m_res[1]));
    end

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
        @(posedge clk);
        #2;
        s_a = a; s_b = b; s_cin = c; s_sub = s; s_start = 1'b1;
        @(posedge clk);
        #2;
        s_start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!if1.done && n < 40);
        if (!if1.done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_res1(input string nm, input logic [W-1:0] s, input logic c, input logic o);
        chk(nm, 32'({if1.ovf, if1.cout, if1.sum}), 32'({o, c, s}));
    endtask

    int n, dc0;

    initial begin
        rst_n = 1'b1;
        s_start = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
        #1 rst_n = 1'b0;

        chk("pin_ff01", 32'(ref_add(8'hFF, 8'h01, 1'b0, 1'b0)), 32'({1'b0, 1'b1, 8'h00}));
        chk("pin_7f00", 32'(ref_add(8'h7F, 8'h00, 1'b1, 1'b0)), 32'({1'b1, 1'b0, 8'h80}));
        chk("pin_sub",  32'(ref_add(8'h80, 8'h01, 1'b0, 1'b1)), 32'({1'b1, 1'b1, 8'h7F}));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'({if1.busy, if1.done, if1.ovf, if1.cout, if1.sum}), 32'd0);
        #1 rst_n = 1'b1;

        // Carry out of the top, latency of STEPS edges
        launch(8'hFF, 8'h01, 1'b0, 1'b0);
        chk("t1_busy", 32'(if1.busy), 32'd1);
        wait_done(n);
        chk("t1_latency", 32'(n), 32'd8);
        chk_res1("t1_res", 8'h00, 1'b1, 1'b0);

        launch(8'h7F, 8'h00, 1'b1, 1'b0);
        wait_done(n);
        chk_res1("t2a_res", 8'h80, 1'b0, 1'b1);
        launch(8'h80, 8'h80, 1'b0, 1'b0);
        wait_done(n);
        chk_res1("t2b_res", 8'h00, 1'b1, 1'b1);

        // Start and operand changes while busy are ignored
        launch(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        s_start = 1'b1; s_a = 8'hFF; s_b = 8'hFF; s_cin = 1'b1;
        @(posedge clk);
        #2;
        s_start = 1'b0;
        dc0 = d1_dones;
        wait_done(n);
        chk_res1("t3_res", 8'h46, 1'b0, 1'b0);
        s_start = 1'b1; s_a = 8'h01; s_b = 8'h02; s_cin = 1'b0;
        @(posedge clk);
        #1;
        chk("t3_b2b_busy", 32'(if1.busy), 32'd1);
        chk("t3_one_done", 32'(d1_dones - dc0), 32'd1);
        s_start = 1'b0;
        wait_done(n);
        chk_res1("t3_b2b_res", 8'h03, 1'b0, 1'b0);

        // Asynchronous abort mid-operation
        launch(8'h0F, 8'h01, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_abort1", 32'({if1.busy, if1.done, if1.ovf, if1.cout, if1.sum}), 32'd0);
        chk("t4_abort4", 32'({if4.busy, if4.done, if4.ovf, if4.cout, if4.sum}), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        launch(8'h10, 8'h20, 1'b0, 1'b0);
        wait_done(n);
        chk_res1("t4_fresh", 8'h30, 1'b0, 1'b0);

        // Four-bit digits finish two edges after the start edge
        launch(8'h3C, 8'h0F, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("t5_d4_early", 32'(if4.done), 32'd0);
        @(posedge clk);
        #1;
        chk("t5_d4_done", 32'(if4.done), 32'd1);
        chk("t5_d4_res", 32'({if4.ovf, if4.cout, if4.sum}), 32'({1'b0, 1'b0, 8'h4B}));
        wait_done(n);
        chk_res1("t5_d1_res", 8'h4B, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        launch(8'h05, 8'h07, 1'b0, 1'b1);
        wait_done(n);
        chk_res1("t6a_res", 8'hFE, 1'b0, 1'b0);
        launch(8'h80, 8'h01, 1'b0, 1'b1);
        wait_done(n);
        chk_res1("t6b_res", 8'h7F, 1'b1, 1'b1);
`endif

        repeat (4) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
